// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon 64/128 key schedule.
// Holds no logic, so it adds no latency and applies no backpressure.
package simon_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0]   word_t;
    typedef word_t               rkey_t;
    typedef logic [4*WORD_W-1:0] key_t;

    localparam word_t C_CONST = 32'hFFFFFFFC;

    // Ascending range, so Z3[0] is the leftmost character of the sequence string.
    localparam logic [0:61] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} ks_state_t;

    function automatic word_t ror(input word_t x, input int unsigned s);
        return (x >> s) | (x << (WORD_W - s));
    endfunction

endpackage

// File: rtl/simon_key_expand.sv
// Combinational m=4 Simon key expansion step that produces the next k3 word.
// Zero latency; it has no handshake and no backpressure.
module simon_key_expand
    import simon_pkg::*;
(
    input  word_t k0,
    input  word_t k1,
    input  word_t k3,
    input  logic  z,
    output word_t knew
);

    word_t tmp_a;
    word_t tmp_b;

    assign tmp_a = ror(k3, 3) ^ k1;
    assign tmp_b = tmp_a ^ ror(tmp_a, 1);
    assign knew  = C_CONST ^ {{(WORD_W-1){1'b0}}, z} ^ k0 ^ tmp_b;

endmodule

// File: rtl/simon_key_sched.sv
// Simon 64/128 round-key sequencer: start -> LOAD (1 cycle) -> NROUNDS round cycles -> DONE (1 cycle).
// No backpressure; start is ignored while busy, and every output decodes registered state only.
module simon_key_sched
    import simon_pkg::*;
#(
    parameter int NROUNDS = 44
)
(
    input  logic  clk,
    input  logic  rst,
    input  logic  start,
    input  key_t  key,
    output logic  load,
    output logic  compute,
    output rkey_t rkey,
    output logic  busy,
    output logic  done
);

    localparam logic [5:0] LAST_ROUND = 6'(NROUNDS - 1);

    ks_state_t  state;
    ks_state_t  state_nxt;
    word_t      k0, k1, k2, k3;
    word_t      knew;
    logic [5:0] round;
    logic       z_bit;

    // When NROUNDS is 62, round reaches 62 after the final shift; keep the index in range there.
    assign z_bit = (round < 6'd62) ? Z3[round] : 1'b0;

    simon_key_expand u_expand (
        .k0   (k0),
        .k1   (k1),
        .k3   (k3),
        .z    (z_bit),
        .knew (knew)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = RUN;
            RUN:     if (round == LAST_ROUND) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k0    <= '0;
            k1    <= '0;
            k2    <= '0;
            k3    <= '0;
            round <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        {k3, k2, k1, k0} <= key;
                        round            <= '0;
                    end
                end
                RUN: begin
                    k0    <= k1;
                    k1    <= k2;
                    k2    <= k3;
                    k3    <= knew;
                    round <= round + 6'd1;
                end
                default: ;
            endcase
        end
    end

    assign load    = (state == LOAD);
    assign compute = (state == RUN);
    assign done    = (state == DONE);
    assign busy    = (state != IDLE);
    assign rkey    = k0;

endmodule

// File: tb/tb_simon_key_sched.sv
// Bench for simon_key_sched: hand-computed key vectors, full-schedule model plus known-answer ciphertext.
// Exercises timing, ignored start/key while busy, mid-run reset and back-to-back restart.
module tb_simon_key_sched;

    localparam int NR = 44;
    localparam logic [127:0] STD_KEY = 128'h1b1a1918_13121110_0b0a0908_03020100;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key = '0;
    logic         load, compute, busy, done;
    logic [31:0]  rkey;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_rk [0:63];
    logic [31:0] got_rk [0:63];
    logic [31:0] done_rk;
    logic [31:0] idle_rk;

    string z3s = "11011011101011000110010111100000010010001010011100110100001111";

    typedef struct {
        logic [127:0] key;
        int           idx;
        logic [31:0]  exp;
    } vec_t;

    vec_t vecs [0:10];

    simon_key_sched #(.NROUNDS(NR)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .key     (key),
        .load    (load),
        .compute (compute),
        .rkey    (rkey),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    // Independent schedule model: k[i+4] = ~k[i] ^ 3 ^ z3[i] ^ t, t = r ^ ror(r,1), r = ror(k[i+3],3) ^ k[i+1].
    task automatic model_keys(input logic [127:0] k);
        logic [31:0] r;
        logic [31:0] t;
        for (int i = 0; i < 4; i++) exp_rk[i] = k[32*i +: 32];
        for (int i = 0; i < 60; i++) begin
            r = {exp_rk[i+3][2:0], exp_rk[i+3][31:3]} ^ exp_rk[i+1];
            t = r ^ {r[0], r[31:1]};
            exp_rk[i+4] = ~exp_rk[i] ^ 32'd3 ^ t ^ {31'd0, (z3s[i] == 8'h31)};
        end
    endtask

    // Status vector is {load, compute, busy, done}.
    task automatic run_block(input logic [127:0] k, input bit hold, input bit disturb, input string tag);
        start = 1'b1;
        key   = k;
        @(posedge clk); #1;
        start = hold;
        chk({tag, " load cycle"}, {load, compute, busy, done}, 4'b1010);
        for (int i = 0; i < NR; i++) begin
            if (disturb) begin
                start = 1'($urandom_range(0, 1));
                key   = {$urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clk); #1;
            chk($sformatf("%s round %0d status", tag, i), {load, compute, busy, done}, 4'b0110);
            got_rk[i] = rkey;
        end
        @(posedge clk); #1;
        chk({tag, " done cycle"}, {load, compute, busy, done}, 4'b0011);
        done_rk = rkey;
        start   = hold;
        @(posedge clk); #1;
        chk({tag, " idle cycle"}, {load, compute, busy, done}, 4'b0000);
        idle_rk = rkey;
    endtask

    task automatic check_sched(input string tag);
        for (int i = 0; i < NR; i++)
            chk($sformatf("%s rkey %0d", tag, i), got_rk[i], exp_rk[i]);
        chk({tag, " rkey in DONE"}, done_rk, exp_rk[NR]);
        chk({tag, " rkey in IDLE"}, idle_rk, exp_rk[NR]);
    endtask

    initial begin
        logic [31:0] x, y, t;
        int          act_cnt;

        vecs[0]  = '{STD_KEY, 0, 32'h03020100};
        vecs[1]  = '{STD_KEY, 1, 32'h0b0a0908};
        vecs[2]  = '{STD_KEY, 2, 32'h13121110};
        vecs[3]  = '{STD_KEY, 3, 32'h1b1a1918};
        vecs[4]  = '{STD_KEY, 4, 32'h70a011c3};
        vecs[5]  = '{128'h0, 0, 32'h00000000};
        vecs[6]  = '{128'h0, 4, 32'hfffffffd};
        vecs[7]  = '{{128{1'b1}}, 0, 32'hffffffff};
        vecs[8]  = '{{128{1'b1}}, 4, 32'h00000002};
        vecs[9]  = '{128'h44444444_33333333_22222222_11111111, 1, 32'h22222222};
        vecs[10] = '{128'h44444444_33333333_22222222_11111111, 3, 32'h44444444};

        // Asynchronous reset asserted mid-cycle must clear outputs before the next edge.
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("reset async outputs", {load, compute, busy, done}, 4'b0000);
        chk("reset async rkey", rkey, 32'h0);
        @(posedge clk); #4 rst = 1'b0;
        act_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if ({load, compute, busy, done} != 4'b0000 || rkey != 32'h0) act_cnt++;
        end
        chk("idle after reset without start", act_cnt, 0);

        for (int i = 0; i <= 10; i++) begin
            if (i == 0 || vecs[i].key != vecs[i-1].key)
                run_block(vecs[i].key, 1'b0, 1'b0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d rkey[%0d]", i, vecs[i].idx), got_rk[vecs[i].idx], vecs[i].exp);
        end

        // Full schedule for the standard key, then encrypt with the observed keys.
        model_keys(STD_KEY);
        run_block(STD_KEY, 1'b0, 1'b0, "std");
        check_sched("std");
        x = 32'h656b696c;
        y = 32'h20646e75;
        for (int i = 0; i < NR; i++) begin
            t = x;
            x = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ got_rk[i];
            y = t;
        end
        chk("std ciphertext", {x, y}, 64'h44c8fc20_b9dfa07a);

        run_block(STD_KEY, 1'b0, 1'b1, "disturbed");
        check_sched("disturbed");
        start = 1'b0;

        // Reset during round 20 aborts at once; no done may follow.
        start = 1'b1;
        key   = STD_KEY;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        chk("abort run round 20 status", {load, compute, busy, done}, 4'b0110);
        chk("abort run round 20 rkey", rkey, exp_rk[20]);
        #2 rst = 1'b1;
        #1;
        chk("abort immediate outputs", {load, compute, busy, done}, 4'b0000);
        chk("abort immediate rkey", rkey, 32'h0);
        @(posedge clk); #2 rst = 1'b0;
        act_cnt = 0;
        for (int i = 0; i < NR + 5; i++) begin
            @(posedge clk); #1;
            if (done || busy || compute) act_cnt++;
        end
        chk("no activity after abort", act_cnt, 0);
        run_block(STD_KEY, 1'b0, 1'b0, "recover");
        check_sched("recover");

        // start held high: each run restarts after exactly one IDLE cycle.
        run_block(STD_KEY, 1'b1, 1'b0, "held0");
        check_sched("held0");
        run_block(STD_KEY, 1'b1, 1'b0, "held1");
        check_sched("held1");
        run_block(STD_KEY, 1'b0, 1'b0, "held2");
        check_sched("held2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
